// File: rtl/bcd_seq_ctrl.sv
// ----------------------------------------------------------------------------
// bcd_seq_ctrl
// Sequential binary-to-BCD converter using the iterative double-dabble method.
// One shift step is performed per clock, so a conversion takes N_in SHIFT
// cycles plus one DONE cycle. Values above 9999 saturate to 9999 and set ovf.
//
// Optional feature:
//   BCD_SEQ_BLANK_EN - when defined, blank is computed as a leading-zero mask
//                      at the end of each conversion; otherwise blank is 0.
//
// Ports:
//   clk      in   single clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   conversion request, honoured only in IDLE
//   bin_in   in   [N_in] binary value captured on the accepted start
//   busy     out  high while in SHIFT or DONE
//   done     out  one-cycle pulse when new digits are presented
//   dig_un   out  [4] BCD units
//   dig_de   out  [4] BCD tens
//   dig_ce   out  [4] BCD hundreds
//   dig_mi   out  [4] BCD thousands
//   ovf      out  captured value exceeded 9999
//   blank    out  [4] leading-zero mask, bit0 units .. bit3 thousands, 1 = off
// ----------------------------------------------------------------------------
module bcd_seq_ctrl #(
    parameter int unsigned N_in = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [N_in-1:0] bin_in,
    output logic            busy,
    output logic            done,
    output logic [3:0]      dig_un,
    output logic [3:0]      dig_de,
    output logic [3:0]      dig_ce,
    output logic [3:0]      dig_mi,
    output logic            ovf,
    output logic [3:0]      blank
);

    localparam int unsigned CNT_W   = $clog2(N_in + 1);
    localparam int unsigned ACC_W   = 16;
    localparam int unsigned BCD_MAX = 9999;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_in-1:0]    sh_q, sh_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   dig_q, dig_d;
    logic [ACC_W-1:0]   acc_adj;
    logic [ACC_W-1:0]   acc_step;

    // Double-dabble correction: add 3 to each nibble >= 5 before shifting.
    always_comb begin
        logic [3:0] nib;
        acc_adj = acc_q;
        nib     = 4'd0;
        for (int i = 0; i < 4; i++) begin
            nib = acc_q[4*i +: 4];
            if (nib >= 4'd5) begin
                acc_adj[4*i +: 4] = nib + 4'd3;
            end
        end
    end

    // Shift the corrected accumulator left, pulling in the binary MSB.
    assign acc_step = (acc_adj << 1) | ACC_W'(sh_q[N_in-1]);

`ifdef BCD_SEQ_BLANK_EN
    logic [3:0] blank_q, blank_d;
`endif

    // Next-state and output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sh_d       = sh_q;
        acc_d      = acc_q;
        ovf_pend_d = ovf_pend_q;
        dig_d      = dig_q;
        ovf_d      = ovf_q;
`ifdef BCD_SEQ_BLANK_EN
        blank_d    = blank_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    sh_d       = bin_in;
                    acc_d      = '0;
                    cnt_d      = CNT_W'(N_in);
                    ovf_pend_d = (32'(bin_in) > 32'(BCD_MAX));
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                sh_d  = sh_q << 1;
                acc_d = acc_step;
                cnt_d = cnt_q - CNT_W'(1);
                // Digits are loaded on the final shift edge so they are valid
                // during the DONE cycle alongside the done pulse.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    dig_d   = ovf_pend_q ? 16'h9999 : acc_step;
                    ovf_d   = ovf_pend_q;
`ifdef BCD_SEQ_BLANK_EN
                    blank_d = {dig_d[15:12] == 4'd0,
                               dig_d[15:8]  == 8'd0,
                               dig_d[15:4]  == 12'd0,
                               1'b0};
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sh_q       <= '0;
            acc_q      <= '0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            dig_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            acc_q      <= acc_d;
            ovf_pend_q <= ovf_pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            dig_q      <= dig_d;
        end
    end

`ifdef BCD_SEQ_BLANK_EN
    // Leading-zero mask register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_q <= 4'b0000;
        end else begin
            blank_q <= blank_d;
        end
    end
    assign blank = blank_q;
`else
    assign blank = 4'b0000;
`endif

    assign busy   = busy_q;
    assign done   = done_q;
    assign ovf    = ovf_q;
    assign dig_un = dig_q[3:0];
    assign dig_de = dig_q[7:4];
    assign dig_ce = dig_q[11:8];
    assign dig_mi = dig_q[15:12];

endmodule

// File: doc/bcd_seq_ctrl.md
BCD_SEQ_CTRL -- requirements
Module: bcd_seq_ctrl

Interface
REQ-001 The block SHALL have parameter N_in, default 10, meaning binary input width; legal range 4..14.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset; it is asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1, conversion request, sampled only in IDLE.
REQ-005 The block SHALL have port bin_in, input, N_in, binary value, captured on the accepted start.
REQ-006 The block SHALL have port busy, output, 1, high in SHIFT and DONE states.
REQ-007 The block SHALL have port done, output, 1, one-cycle pulse marking new digits.
REQ-008 The block SHALL have ports dig_un, dig_de, dig_ce, dig_mi, output, 4 each, registered BCD units, tens, hundreds and thousands.
REQ-009 The block SHALL have port ovf, output, 1, registered flag set when the captured value exceeds 9999.
REQ-010 The block SHALL have port blank, output, 4, leading-zero mask; bit0 is units and bit3 is thousands; 1 means digit off.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-012 In IDLE with start=1, the block SHALL load bin_in into the shift register and clear the 16-bit BCD accumulator.
- On the same edge it SHALL load the iteration counter with N_in and enter SHIFT.
REQ-013 In IDLE with start=0, the block SHALL hold all state.
REQ-014 Each SHIFT cycle SHALL perform one double-dabble step on the accumulator.
- Add 3 to every 4-bit nibble whose value is >= 5.
- Shift {accumulator, shift register} left by one bit.
- Decrement the counter.
REQ-015 When the counter reaches 0 after the last shift, the FSM SHALL enter DONE.
REQ-016 In DONE, the block SHALL copy the accumulator nibbles to dig_un..dig_mi, assert done for exactly that cycle, and return to IDLE.
REQ-017 Latency SHALL be fixed: start accepted at edge 0 gives done=1 in cycle N_in+1, with outputs updated on the same edge.
REQ-018 The block SHALL ignore start while busy=1; bin_in SHALL be don't-care outside the accepting edge.
REQ-019 A start asserted in the cycle after done SHALL be accepted, giving back-to-back conversions every N_in+2 cycles.
REQ-020 If the captured value is > 9999, the block SHALL set ovf=1 in DONE and saturate all four digits to 9; otherwise it SHALL clear ovf.
- This case is reachable only for N_in = 14.
REQ-021 Digit, ovf and blank outputs SHALL hold their last values until the next DONE.
REQ-022 The block SHALL use no division or modulo operators; the conversion is iterative only.

Reset
REQ-023 rst_n=0 SHALL force IDLE, clear the counter, shift register and accumulator, and set busy=0, done=0, all digits=0, ovf=0 and blank=0, regardless of clk.
REQ-024 Reset asserted mid-conversion SHALL abort the conversion with no done pulse.
- The first start after reset deasserts SHALL be accepted normally.

Configuration
REQ-025 Macro BCD_SEQ_BLANK_EN, when defined, SHALL compute blank in DONE.
- Set a bit for each digit that is zero and has all higher digits zero.
- The units bit SHALL always be 0.
REQ-026 Without BCD_SEQ_BLANK_EN, blank SHALL be tied to 4'b0000 and no blanking logic SHALL be synthesized.

Verification
REQ-027 Basic conversion: N_in=10, bin_in=0, start for one cycle -> done in cycle 11; digits 0,0,0,0; ovf=0.
REQ-028 Full-scale input: N_in=10, bin_in=1023 -> dig_mi=1, dig_ce=0, dig_de=2, dig_un=3; busy high for cycles 1..11.
REQ-029 Start while busy: bin_in=999 accepted, then start=1 with bin_in=5 at cycle 4 -> a single done only; digits 0,9,9,9.
- A follow-up start in the cycle after done -> digits 0,0,0,5 exactly 12 cycles later.
REQ-030 Reset mid-op: rst_n pulsed low at cycle 6 of a conversion of 512 -> no done pulse; all outputs 0.
- A new start with 512 -> digits 0,5,1,2.
REQ-031 Overflow: N_in=14, bin_in=12345 -> ovf=1, digits 9,9,9,9.
- Then bin_in=9999 -> ovf=0, digits 9,9,9,9.
REQ-032 Blanking, with BCD_SEQ_BLANK_EN: bin_in=7 -> blank=4'b1110; bin_in=0 -> blank=4'b1110; bin_in=1000 -> blank=4'b0000.
- Without the macro: blank=0 in all three cases.
